// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of the dual-clock FIFO. Everything here runs on r_clk.
// It brings the Gray write pointer across with a flop chain. It keeps the
// binary and Gray read pointers, and registers the empty flag, the
// almost-empty flag and the fill level.
//
// Parameters:
//   ADDR_W      memory address width (depth = 2**ADDR_W, pointers ADDR_W+1)
//   SYNC_STAGES flop stages on the incoming write pointer (2..4)
//   AE_LEVEL    r_almost_empty is high while level <= AE_LEVEL
//
// Ports:
//   r_clk          read clock
//   r_rst_n        asynchronous active-low reset
//   r_inc          read request
//   w_ptr          Gray write pointer from the write domain (asynchronous)
//   r_addr         registered memory read address
//   r_ptr          registered Gray read pointer, sent to the write domain
//   r_empty        registered empty flag
//   r_almost_empty registered level <= AE_LEVEL flag
//   r_level        registered number of readable words (0..2**ADDR_W)
//   r_underflow    one-cycle pulse after a read attempt while empty
//
// Optional feature: define FIFO_RD_UNDERFLOW_EN to build the underflow pulse
// register. Without it, r_underflow is tied to 0 and no logic is generated.
//
// Read handshake: r_inc is a request. It is accepted on a clock edge only
// when r_empty is 0 at that edge. There is no ready output. A request made
// while empty is dropped and leaves all read state unchanged.
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_LEVEL    = 2
) (
    input  logic              r_clk,
    input  logic              r_rst_n,
    input  logic              r_inc,
    input  logic [ADDR_W:0]   w_ptr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W:0]   r_ptr,
    output logic              r_empty,
    output logic              r_almost_empty,
    output logic [ADDR_W:0]   r_level,
    output logic              r_underflow
);

    localparam logic [ADDR_W:0] AE_THR = AE_LEVEL[ADDR_W:0];

    // Write-pointer synchronizer chain. Stage 0 is the metastability catcher.
    logic [ADDR_W:0] r_sync [SYNC_STAGES];
    logic [ADDR_W:0] w_rq_wptr;
    logic [ADDR_W:0] w_rq_wptr_bin;

    // Binary read pointer, one bit wider than the address. The extra MSB
    // tells full (difference 2**ADDR_W) apart from empty.
    logic [ADDR_W:0] r_bin;
    logic [ADDR_W:0] w_bin_next;
    logic [ADDR_W:0] w_ptr_next;
    logic [ADDR_W:0] w_level_next;
    logic            w_rd_en;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_ptr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_rq_wptr = r_sync[SYNC_STAGES-1];

    // Gray to binary: bin bit i is the XOR of all Gray bits from i up to MSB.
    always_comb begin
        w_rq_wptr_bin = '0;
        for (int i = 0; i <= int'(ADDR_W); i++) begin
            w_rq_wptr_bin[i] = ^(w_rq_wptr >> i);
        end
    end

    assign w_rd_en      = r_inc & ~r_empty;
    assign w_bin_next   = r_bin + {{ADDR_W{1'b0}}, w_rd_en};
    assign w_ptr_next   = w_bin_next ^ (w_bin_next >> 1);
    // Modulo subtraction. It stays correct across pointer wrap because both
    // operands carry the extra MSB.
    assign w_level_next = w_rq_wptr_bin - w_bin_next;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_bin          <= '0;
            r_ptr          <= '0;
            r_addr         <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
        end else begin
            r_bin          <= w_bin_next;
            r_ptr          <= w_ptr_next;
            r_addr         <= w_bin_next[ADDR_W-1:0];
            // The compare uses the Gray pointers. The synchronized write
            // pointer is never ahead of the real one, so empty can only be
            // pessimistic.
            r_empty        <= (w_ptr_next == w_rq_wptr);
            r_almost_empty <= (w_level_next <= AE_THR);
            r_level        <= w_level_next;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_inc & r_empty;
        end
    end
`else
    assign r_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Bench for fifo_rd_ctrl with ADDR_W=3, SYNC_STAGES=2, AE_LEVEL=2.
// The reference model tracks integer counts of words written and words read.
// The writer's count becomes visible SYNC_STAGES edges after it is sampled.
// Level, flags, address and pointer all follow from those counts.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int ADDR_W = 3;
    localparam int SYNC   = 2;
    localparam int AE     = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              r_clk;
    logic              r_rst_n;
    logic              r_inc;
    logic [ADDR_W:0]   w_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_ptr;
    logic              r_empty;
    logic              r_almost_empty;
    logic [ADDR_W:0]   r_level;
    logic              r_underflow;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int w_cnt;
    int rd_cnt;
    int wq[$];
    int m_level;
    bit m_empty;
    bit m_ae;
    bit m_uf;

    fifo_rd_ctrl #(
        .ADDR_W(ADDR_W),
        .SYNC_STAGES(SYNC),
        .AE_LEVEL(AE)
    ) dut (
        .r_clk(r_clk),
        .r_rst_n(r_rst_n),
        .r_inc(r_inc),
        .w_ptr(w_ptr),
        .r_addr(r_addr),
        .r_ptr(r_ptr),
        .r_empty(r_empty),
        .r_almost_empty(r_almost_empty),
        .r_level(r_level),
        .r_underflow(r_underflow)
    );

    // ---------------- clock / reset ----------------
    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    function automatic logic [ADDR_W:0] gray(input int n);
        logic [ADDR_W:0] b;
        b = 4'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int n);
        return 3'(n % DEPTH);
    endfunction

    task automatic model_clear();
        w_cnt = 0;
        rd_cnt = 0;
        wq.delete();
        m_level = 0;
        m_empty = 1'b1;
        m_ae = 1'b1;
        m_uf = 1'b0;
    endtask

    function automatic bit exp_uf(input bit v);
`ifdef FIFO_RD_UNDERFLOW_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // ---------------- driver ----------------
    // One clock cycle. It drives inputs, waits for the edge, advances the
    // model, and returns 1 time unit after the edge so callers sample there.
    task automatic tick(input bit inc);
        int vis;
        r_inc = inc;
        w_ptr = gray(w_cnt);
        @(posedge r_clk);
        vis = (wq.size() >= SYNC) ? wq[wq.size() - SYNC] : 0;
        wq.push_back(w_cnt);
        m_uf = inc && m_empty;
        if (inc && m_empty == 1'b0) rd_cnt++;
        m_level = vis - rd_cnt;
        m_empty = (m_level == 0);
        m_ae = (m_level <= AE);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        r_rst_n = 1'b0;
        r_inc = 1'b0;
        w_ptr = '0;
        model_clear();
        #12;
        tests_run++;
        if (r_empty !== 1'b1 || r_almost_empty !== 1'b1 || r_level !== 4'd0 ||
            r_addr !== 3'd0 || r_ptr !== 4'd0 || r_underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: empty=%b ae=%b level=%0d addr=%0d ptr=%b uf=%b, required 1 1 0 0 0000 0",
                     r_empty, r_almost_empty, r_level, r_addr, r_ptr, r_underflow);
        end
        @(negedge r_clk);
        r_rst_n = 1'b1;
    endtask

    task automatic test_write_propagation();
        w_cnt = 3;
        tick(1'b0);
        tests_run++;
        if (r_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL wprop_edge1_empty: got %b, required 1", r_empty);
        end
        tick(1'b0);
        tests_run++;
        if (r_empty !== 1'b1 || r_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL wprop_edge2: empty=%b level=%0d, required 1 0", r_empty, r_level);
        end
        tick(1'b0);
        tests_run++;
        if (r_empty !== 1'b0 || r_level !== 4'd3 || r_almost_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL wprop_edge3: empty=%b level=%0d ae=%b, required 0 3 0",
                     r_empty, r_level, r_almost_empty);
        end
        tick(1'b0);
        tests_run++;
        if (r_almost_empty !== 1'b0 || r_level !== 4'd3) begin
            tests_failed++;
            $display("FAIL wprop_hold: ae=%b level=%0d, required 0 3", r_almost_empty, r_level);
        end
    endtask

    task automatic test_full_and_drain();
        w_cnt = rd_cnt + DEPTH;
        repeat (3) tick(1'b0);
        tests_run++;
        if (r_level !== 4'd8 || r_empty !== 1'b0 || r_almost_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_level: level=%0d empty=%b ae=%b, required 8 0 0",
                     r_level, r_empty, r_almost_empty);
        end
        for (int lvl = 7; lvl >= 0; lvl--) begin
            tick(1'b1);
            tests_run++;
            if (r_level !== 4'(lvl) || r_almost_empty !== (lvl <= AE) ||
                r_empty !== (lvl == 0)) begin
                tests_failed++;
                $display("FAIL drain_step: level=%0d ae=%b empty=%b, required %0d %b %b",
                         r_level, r_almost_empty, r_empty, lvl, (lvl <= AE), (lvl == 0));
            end
        end
        tick(1'b1);
        tests_run++;
        if (r_addr !== 3'd0 || r_level !== 4'd0 || r_ptr !== 4'b1100) begin
            tests_failed++;
            $display("FAIL drain_hold: addr=%0d level=%0d ptr=%b, required 0 0 1100",
                     r_addr, r_level, r_ptr);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W:0]   prev_ptr;
        logic [ADDR_W-1:0] prev_addr;
        w_cnt = 2 * DEPTH;
        repeat (3) tick(1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            prev_ptr = r_ptr;
            prev_addr = r_addr;
            tick(1'b1);
            tests_run++;
            if ($countones(prev_ptr ^ r_ptr) != 1 || r_ptr !== gray(rd_cnt)) begin
                tests_failed++;
                $display("FAIL wrap_gray_step: %b -> %b, required -> %b one-bit",
                         prev_ptr, r_ptr, gray(rd_cnt));
            end
        end
        tests_run++;
        if (prev_ptr !== 4'b1000 || r_ptr !== 4'b0000 || prev_addr !== 3'd7 || r_addr !== 3'd0) begin
            tests_failed++;
            $display("FAIL wrap_last: ptr %b->%b addr %0d->%0d, required 1000->0000 7->0",
                     prev_ptr, r_ptr, prev_addr, r_addr);
        end
    endtask

    task automatic test_underflow();
        logic [ADDR_W:0] ptr0;
        ptr0 = r_ptr;
        tick(1'b1);
        tests_run++;
        if (r_ptr !== ptr0 || r_addr !== 3'd0 || r_level !== 4'd0 || r_empty !== 1'b1 ||
            r_underflow !== exp_uf(1'b1)) begin
            tests_failed++;
            $display("FAIL underflow_pulse: ptr=%b addr=%0d level=%0d empty=%b uf=%b, required %b 0 0 1 %b",
                     r_ptr, r_addr, r_level, r_empty, r_underflow, ptr0, exp_uf(1'b1));
        end
        tick(1'b0);
        tests_run++;
        if (r_underflow !== 1'b0 || r_ptr !== ptr0) begin
            tests_failed++;
            $display("FAIL underflow_clear: uf=%b ptr=%b, required 0 %b", r_underflow, r_ptr, ptr0);
        end
    endtask

    task automatic test_concurrent();
        w_cnt = rd_cnt + 4;
        repeat (3) tick(1'b0);
        w_cnt = w_cnt + 2;
        tick(1'b0);
        tick(1'b0);
        tests_run++;
        if (r_level !== 4'd4) begin
            tests_failed++;
            $display("FAIL concurrent_pre: level=%0d, required 4", r_level);
        end
        tick(1'b1);
        tests_run++;
        if (r_level !== 4'd5 || r_empty !== 1'b0 || r_almost_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL concurrent_level: level=%0d empty=%b ae=%b, required 5 0 0",
                     r_level, r_empty, r_almost_empty);
        end
    endtask

    task automatic test_random();
        int add;
        for (int c = 0; c < 400; c++) begin
            add = $urandom_range(0, 2);
            if (w_cnt + add - rd_cnt > DEPTH) add = DEPTH - (w_cnt - rd_cnt);
            w_cnt = w_cnt + add;
            tick(1'($urandom_range(0, 9) < 6));
            tests_run++;
            if (r_level !== 4'(m_level) || r_empty !== m_empty || r_almost_empty !== m_ae ||
                r_addr !== addr_of(rd_cnt) || r_ptr !== gray(rd_cnt) ||
                r_underflow !== exp_uf(m_uf)) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: level=%0d empty=%b ae=%b addr=%0d ptr=%b uf=%b, required %0d %b %b %0d %b %b",
                         c, r_level, r_empty, r_almost_empty, r_addr, r_ptr, r_underflow,
                         m_level, m_empty, m_ae, addr_of(rd_cnt), gray(rd_cnt), exp_uf(m_uf));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        w_cnt = rd_cnt + 6;
        repeat (3) tick(1'b0);
        tick(1'b1);
        tests_run++;
        if (r_level !== 4'd5) begin
            tests_failed++;
            $display("FAIL midreset_setup: level=%0d, required 5", r_level);
        end
        r_inc = 1'b1;
        #2;
        r_rst_n = 1'b0;
        #1;
        tests_run++;
        if (r_empty !== 1'b1 || r_almost_empty !== 1'b1 || r_level !== 4'd0 ||
            r_addr !== 3'd0 || r_ptr !== 4'd0 || r_underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_values: empty=%b ae=%b level=%0d addr=%0d ptr=%b uf=%b, required 1 1 0 0 0000 0",
                     r_empty, r_almost_empty, r_level, r_addr, r_ptr, r_underflow);
        end
        model_clear();
        r_inc = 1'b0;
        w_ptr = '0;
        @(negedge r_clk);
        r_rst_n = 1'b1;
        w_cnt = 2;
        repeat (3) tick(1'b0);
        tests_run++;
        if (r_level !== 4'd2 || r_almost_empty !== 1'b1 || r_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_fill: level=%0d ae=%b empty=%b, required 2 1 0",
                     r_level, r_almost_empty, r_empty);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_propagation();
        test_full_and_drain();
        test_wrap();
        test_underflow();
        test_concurrent();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Parametrised read-side controller for the dual-clock FIFO. It lives entirely in the `r_clk` domain. It synchronises the Gray-coded write pointer internally, maintains the binary and Gray read pointers, and produces registered empty, almost-empty and fill-level outputs. It drives the read address of the FIFO memory and returns its Gray pointer to the write-side controller.

## Interface
- `ADDR_W`, 3: memory address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- `SYNC_STAGES`, 2: flop stages synchronising `w_ptr` into `r_clk` (legal 2..4).
- `AE_LEVEL`, 2: `r_almost_empty` asserts while level ≤ AE_LEVEL (legal 0..2^ADDR_W-1).

Ports:
- `r_clk`  in  1  read clock.
- `r_rst_n`  in  1  reset, asynchronous, active-low.
- `r_inc`  in  1  read request; consumed only when `r_empty`=0.
- `w_ptr`  in  ADDR_W+1  Gray write pointer from the write domain (asynchronous).
- `r_addr`  out  ADDR_W  memory read address, registered.
- `r_ptr`  out  ADDR_W+1  Gray read pointer to the write domain, registered.
- `r_empty`  out  1  FIFO empty, registered.
- `r_almost_empty`  out  1  level ≤ AE_LEVEL, registered.
- `r_level`  out  ADDR_W+1  words available (0..2^ADDR_W), registered.
- `r_underflow`  out  1  one-cycle pulse on a read attempt while empty (see Configuration).

## Operation
- Synchronizer: SYNC_STAGES-deep flop chain on `w_ptr`; all stages reset to 0. Its output is `rq_wptr`, and `rq_wptr_bin` is its Gray-to-binary conversion (prefix XOR from the MSB down).
- Read enable: `rd_en = r_inc & ~r_empty`.
- `r_bin_next = r_bin + rd_en`, computed modulo 2^(ADDR_W+1). Wrap-around is natural overflow with no special case.
- `r_ptr_next = r_bin_next ^ (r_bin_next >> 1)`.
- Registered on each `r_clk` edge:
  - `r_bin` ← `r_bin_next`
  - `r_ptr` ← `r_ptr_next`
  - `r_addr` ← `r_bin_next[ADDR_W-1:0]`
  - `r_empty` ← (`r_ptr_next == rq_wptr`)
  - `r_level` ← `rq_wptr_bin - r_bin_next` (ADDR_W+1 bits, modulo)
  - `r_almost_empty` ← (`rq_wptr_bin - r_bin_next`) ≤ AE_LEVEL
- Empty/full distinction relies on the extra MSB. A difference of 2^ADDR_W means full, so `r_level` = 2^ADDR_W and `r_empty` = 0.
- `r_inc` while `r_empty`=1:
  - Pointers, address and level do not change.
  - `r_underflow` pulses (when enabled).
- `r_empty` is pessimistic. It can stay high for up to SYNC_STAGES+1 cycles after a write and it never deasserts falsely.

## Timing
- Reset values (asynchronous, immediate, also mid-operation):
  - `r_addr`=0, `r_ptr`=0, `r_level`=0, `r_underflow`=0
  - `r_empty`=1, `r_almost_empty`=1
  - internal `r_bin`=0, synchronizer stages=0
- Deassertion of reset is synchronous to `r_clk`, supplied externally.
- Read latency: an accepted `r_inc` at edge N updates `r_addr`, `r_ptr`, `r_empty`, `r_level` and `r_almost_empty` at edge N.
  - The memory presents the next word from the new `r_addr`.
  - The word read in the current cycle is the one at `r_addr` before the edge.
- Write visibility: a `w_ptr` change stable before edge M appears at `rq_wptr` after edge M+SYNC_STAGES-1. The flags and level reflect it at edge M+SYNC_STAGES.
- Simultaneous read and newly synchronised write in one cycle: both apply. The level is computed from `r_bin_next` and the fresh `rq_wptr_bin`.
- `r_ptr` changes by exactly one bit per accepted read, which makes it safe for the write-side synchronizer.

## Configuration
- Macro `FIFO_RD_UNDERFLOW_EN`.
- Defined: `r_underflow` is registered and equals 1 for exactly the cycle after an edge where `r_inc`=1 and `r_empty`=1, otherwise 0.
- Not defined: `r_underflow` is tied to 0 and no logic is generated. The port exists in both cases.

## Test plan
All scenarios use ADDR_W=3, SYNC_STAGES=2, AE_LEVEL=2.
- **Reset:** assert `r_rst_n`=0 mid-read with level 5 → all outputs return immediately to `r_empty`=1, `r_almost_empty`=1, `r_level`=0, `r_addr`=0, `r_ptr`=0.
- **Write propagation:** drive `w_ptr`=Gray(3)=0011 from empty → `r_empty` falls and `r_level`=3 exactly 2 edges later. `r_almost_empty` stays 0 after level reaches 3.
- **Full and drain:** drive `w_ptr`=Gray(8)=1100 and hold `r_inc`=1 → `r_level` goes 8,7,…,0. `r_almost_empty` rises when level reaches 2. `r_empty` rises when level reaches 0, and `r_addr` then holds 0.
- **Wrap-around:** after 16 cumulative writes and reads, check that `r_ptr` steps from 1000 to 0000, `r_addr` steps 7→0, and `r_ptr` has one-bit changes throughout.
- **Underflow:** `r_inc`=1 while empty → pointers unchanged. `r_underflow` is a one-cycle pulse with the macro defined and constantly 0 without it.
- **Concurrent events:** read accepted at level 4 in the same cycle that `rq_wptr` advances by 2 → `r_level`=5.
